uart_rx: RTL

16x-oversampling UART receiver. It consumes the `s_tick` pulse stream from `baud_rate_generator` and deserialises frames on the `rx` line into parallel bytes: start bit, DBIT data bits LSB first, no parity, stop bit(s). Each received word is presented on `dout` with a one-cycle `rx_done_tick` and a frame-error flag. It is the receive-side counterpart of the transmitter in the UART datapath and shares that transmitter's tick source.

---
 rtl/uart_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start bit, DBIT data bits LSB first, no parity, stop period.
// Consumes the shared s_tick enable and reports each word with a one-cycle done pulse.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [4:0] MID_START = 5'd7;
    localparam logic [4:0] MID_BIT   = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);

    state_t          r_state, w_state_next;
    logic            r_sync1, r_sync2;
    logic            w_rx_s;
    logic [4:0]      r_s_cnt, w_s_cnt_next;
    logic [2:0]      r_n_cnt, w_n_cnt_next;
    logic [DBIT-1:0] r_b, w_b_next;
    logic [DBIT-1:0] r_dout, w_dout_next;
    logic            r_done, w_done_next;
    logic            r_ferr, w_ferr_next;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values; blocking here would
            // let r_sync2 see this cycle's r_sync1 and collapse the synchroniser to one flop.
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_s_cnt <= w_s_cnt_next;
            r_n_cnt <= w_n_cnt_next;
            r_b     <= w_b_next;
            r_dout  <= w_dout_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that skipped an
        // assignment would otherwise infer a latch.
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        w_n_cnt_next = r_n_cnt;
        w_b_next     = r_b;
        w_dout_next  = r_dout;
        w_ferr_next  = r_ferr;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = S_START;
                    w_s_cnt_next = '0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (r_s_cnt == MID_START) begin
                        // A line that is high again mid start bit was only a glitch.
                        if (!w_rx_s) begin
                            w_state_next = S_DATA;
                            w_s_cnt_next = '0;
                            w_n_cnt_next = '0;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (r_s_cnt == MID_BIT) begin
                        w_s_cnt_next = '0;
                        w_b_next     = {w_rx_s, r_b[DBIT-1:1]};
                        if (r_n_cnt == LAST_BIT) begin
                            w_state_next = S_STOP;
                        end else begin
                            w_n_cnt_next = r_n_cnt + 3'd1;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end
            end
            S_STOP: begin
                if (s_tick) begin
                    if (r_s_cnt == STOP_LAST) begin
                        w_dout_next  = r_b;
                        w_ferr_next  = ~w_rx_s;
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;

endmodule
